// File: rtl/cpu_pkg.sv
// Shared encodings between the CPU controller and datapath: control-word bit
// positions, opcode values and the control-word width.
package cpu_pkg;

  localparam int CTRL_W = 15;

  localparam int J   = 0;
  localparam int CO  = 1;
  localparam int CE  = 2;
  localparam int OI  = 3;
  localparam int BI  = 4;
  localparam int SU  = 5;
  localparam int SO  = 6;
  localparam int AO  = 7;
  localparam int AI  = 8;
  localparam int II  = 9;
  localparam int IO  = 10;
  localparam int RO  = 11;
  localparam int RI  = 12;
  localparam int MI  = 13;
  localparam int HLT = 14;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/cpu_ram16x8.sv
// Program/data RAM: synchronous write, asynchronous read. The load port takes
// over the write side whenever load_mode is high.
module cpu_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              load_mode,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = we;
    wr_addr = addr;
    wr_data = wdata;
    if (load_mode) begin
      wr_en   = prog_we;
      wr_addr = prog_addr;
      wr_data = prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 8-bit CPU datapath: executes one controller control word per
// clock; out_valid is a one-cycle strobe marking a fresh out_value (no ready).
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] ctrlwrd,
  input  logic              load_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  output logic              halted,
  output logic              carry,
  output logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus,
  output logic              bus_conflict
);

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic [DATA_W-1:0] ram_rdata, alu;
  logic [DATA_W:0]   b_op, sum;
  logic [2:0]        n_drivers;
  logic              run;

  assign run = !load_mode && !halted_q;

  // Reset gates both write paths so an asserted rst_n never commits a RAM write.
  cpu_ram16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .load_mode (load_mode),
    .we        (rst_n && run && ctrlwrd[RI]),
    .addr      (mar_q),
    .wdata     (bus),
    .prog_we   (rst_n && prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .rdata     (ram_rdata)
  );

  always_comb begin
    b_op = ctrlwrd[SU] ? ({1'b0, ~b_q} + (DATA_W+1)'(1)) : {1'b0, b_q};
    sum  = {1'b0, a_q} + b_op;
    alu  = sum[DATA_W-1:0];
  end

  always_comb begin
    if (ctrlwrd[RO])      bus = ram_rdata;
    else if (ctrlwrd[IO]) bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    else if (ctrlwrd[AO]) bus = a_q;
    else if (ctrlwrd[SO]) bus = alu;
    else if (ctrlwrd[CO]) bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    else                  bus = '0;
    n_drivers = {2'b0, ctrlwrd[RO]} + {2'b0, ctrlwrd[IO]} + {2'b0, ctrlwrd[AO]}
              + {2'b0, ctrlwrd[SO]} + {2'b0, ctrlwrd[CO]};
    bus_conflict = n_drivers > 3'd1;
  end

  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    if (run) begin
      if (ctrlwrd[MI]) mar_d = bus[ADDR_W-1:0];
      if (ctrlwrd[II]) ir_d = bus;
      if (ctrlwrd[AI]) a_d = bus;
      if (ctrlwrd[BI]) b_d = bus;
      if (ctrlwrd[OI]) begin
        out_d       = bus;
        out_valid_d = 1'b1;
      end
      if (ctrlwrd[J])       pc_d = bus[ADDR_W-1:0];
      else if (ctrlwrd[CE]) pc_d = pc_q + 1'b1;
      if (ctrlwrd[SO]) begin
        carry_d = sum[DATA_W];
        zero_d  = (alu == '0);
      end
      if (ctrlwrd[HLT]) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign instruction = ir_q[DATA_W-1 -: 4];
  assign out_value   = out_q;
  assign out_valid   = out_valid_q;
  assign halted      = halted_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign pc          = pc_q;

endmodule
